// File: rtl/change_dispenser_pkg.sv
// Shared constants for the change dispenser: coin codes, coin values, FSM encoding, count widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: COIN_* type codes, coin_value() cents lookup, ST_* state codes, coin_counts_t.
package change_dispenser_pkg;

   localparam int COIN_TYPE_W   = 2;
   localparam int CNT_DOLLAR_W  = 1;
   localparam int CNT_QUARTER_W = 2;
   localparam int CNT_DIME_W    = 4;
   localparam int CNT_NICKEL_W  = 5;
   localparam int ITEM_W        = 3;

   localparam logic [COIN_TYPE_W-1:0] COIN_NICKEL  = 2'd0;
   localparam logic [COIN_TYPE_W-1:0] COIN_DIME    = 2'd1;
   localparam logic [COIN_TYPE_W-1:0] COIN_QUARTER = 2'd2;
   localparam logic [COIN_TYPE_W-1:0] COIN_DOLLAR  = 2'd3;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DOLLAR  = 3'd1;
   localparam logic [2:0] ST_QUARTER = 3'd2;
   localparam logic [2:0] ST_DIME    = 3'd3;
   localparam logic [2:0] ST_NICKEL  = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_FAULT   = 3'd6;

   typedef struct packed {
      logic [CNT_DOLLAR_W-1:0]  dollar;
      logic [CNT_QUARTER_W-1:0] quarters;
      logic [CNT_DIME_W-1:0]    dimes;
      logic [CNT_NICKEL_W-1:0]  nickels;
   } coin_counts_t;

   // Value in cents of one coin of the given type.
   function automatic logic [6:0] coin_value(input logic [COIN_TYPE_W-1:0] t);
      logic [6:0] v;
      case (t)
         COIN_DOLLAR:  v = 7'd100;
         COIN_QUARTER: v = 7'd25;
         COIN_DIME:    v = 7'd10;
         default:      v = 7'd5;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin ejector handshake: one coin presented per valid/ack exchange.
// Latency: n/a (wires only).
// Backpressure: ejector holds off by leaving coin_ack low; presenter keeps coin_type stable.
// Ports: coin_valid/coin_type driven by the dispenser (master), coin_ack by the ejector (slave).
interface change_dispenser_if;
   import change_dispenser_pkg::*;

   logic                   coin_valid;
   logic [COIN_TYPE_W-1:0] coin_type;
   logic                   coin_ack;

   modport master (output coin_valid, output coin_type, input coin_ack);
   modport slave  (input coin_valid, input coin_type, output coin_ack);
endinterface

// File: rtl/change_dispenser_coin_timeout_ctr.sv
// Counts cycles a presented coin waits for an ack; flags when the wait reaches ACK_TIMEOUT.
// Latency: expired is combinational on the edge that would make the count reach ACK_TIMEOUT.
// Backpressure: none; clear has priority over enable.
// Ports: clk, rst_n (sync, active low), clear, enable, expired.
module coin_timeout_ctr #(
   parameter int ACK_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [W-1:0] LIMIT_M1 = W'(ACK_TIMEOUT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // The increment taking the count from ACK_TIMEOUT-1 to ACK_TIMEOUT is the expiry,
   // so the counter itself never has to hold the value ACK_TIMEOUT.
   always_comb begin
      expired = enable && !clear && (cnt_q == LIMIT_M1);
      cnt_d   = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Latches one transaction's coin counts and ejects them largest-first over a valid/ack handshake.
// Latency: first coin_valid 2 edges after load if a dollar is due; done 5 cycles after an empty load.
// Backpressure: coin held until coin_ack; ACK_TIMEOUT cycles without ack enters FAULT.
// Ports: clk, rst_n (sync, active low), load + change_* counts + item_dispensed, clear_fault,
//        ej (coin_valid/coin_type/coin_ack), busy, done, item_out, total_cents, fault.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int ACK_TIMEOUT = 64,
   parameter int TOT_W       = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [CNT_DOLLAR_W-1:0]  change_dollar,
   input  logic [CNT_QUARTER_W-1:0] change_quarters,
   input  logic [CNT_DIME_W-1:0]    change_dimes,
   input  logic [CNT_NICKEL_W-1:0]  change_nickels,
   input  logic [ITEM_W-1:0]        item_dispensed,
   input  logic                     clear_fault,
   change_dispenser_if.master       ej,
   output logic                     busy,
   output logic                     done,
   output logic [ITEM_W-1:0]        item_out,
   output logic [TOT_W-1:0]         total_cents,
   output logic                     fault
);

   logic [2:0]             state_q, state_d;
   coin_counts_t           cnt_q, cnt_d;
   logic                   coin_valid_q, coin_valid_d;
   logic [COIN_TYPE_W-1:0] coin_type_q, coin_type_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [ITEM_W-1:0]      item_q, item_d;
   logic [TOT_W-1:0]       total_q, total_d;
   logic                   fault_q, fault_d;

   logic                   cur_zero;
   logic [COIN_TYPE_W-1:0] cur_type;
   logic [2:0]             next_st;
   logic                   tmo_en;
   logic                   tmo_expired;

   // Ack is only meaningful while a coin is presented; otherwise it is ignored.
   assign tmo_en = coin_valid_q && !ej.coin_ack;

   coin_timeout_ctr #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_tmo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!tmo_en),
      .enable  (tmo_en),
      .expired (tmo_expired)
   );

   // Per-denomination view of the current coin state.
   always_comb begin
      cur_zero = 1'b1;
      cur_type = COIN_NICKEL;
      next_st  = ST_DONE;
      case (state_q)
         ST_DOLLAR: begin
            cur_zero = (cnt_q.dollar == '0);
            cur_type = COIN_DOLLAR;
            next_st  = ST_QUARTER;
         end
         ST_QUARTER: begin
            cur_zero = (cnt_q.quarters == '0);
            cur_type = COIN_QUARTER;
            next_st  = ST_DIME;
         end
         ST_DIME: begin
            cur_zero = (cnt_q.dimes == '0);
            cur_type = COIN_DIME;
            next_st  = ST_NICKEL;
         end
         ST_NICKEL: begin
            cur_zero = (cnt_q.nickels == '0);
            cur_type = COIN_NICKEL;
            next_st  = ST_DONE;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      coin_valid_d = coin_valid_q;
      coin_type_d  = coin_type_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      item_d       = item_q;
      total_d      = total_q;
      fault_d      = fault_q;

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               cnt_d.dollar   = change_dollar;
               cnt_d.quarters = change_quarters;
               cnt_d.dimes    = change_dimes;
               cnt_d.nickels  = change_nickels;
               item_d         = item_dispensed;
               total_d        = '0;
               busy_d         = 1'b1;
               state_d        = ST_DOLLAR;
            end
         end

         ST_DOLLAR, ST_QUARTER, ST_DIME, ST_NICKEL: begin
            if (coin_valid_q) begin
               if (ej.coin_ack) begin
                  // Dropping valid here forces the one-cycle gap between coins.
                  coin_valid_d = 1'b0;
                  total_d      = total_q + TOT_W'(coin_value(coin_type_q));
                  case (state_q)
                     ST_DOLLAR:  cnt_d.dollar   = cnt_q.dollar - 1'b1;
                     ST_QUARTER: cnt_d.quarters = cnt_q.quarters - 1'b1;
                     ST_DIME:    cnt_d.dimes    = cnt_q.dimes - 1'b1;
                     default:    cnt_d.nickels  = cnt_q.nickels - 1'b1;
                  endcase
               end else if (tmo_expired) begin
                  coin_valid_d = 1'b0;
                  fault_d      = 1'b1;
                  state_d      = ST_FAULT;
               end
            end else if (cur_zero) begin
               state_d = next_st;
               done_d  = (next_st == ST_DONE);
            end else begin
               coin_valid_d = 1'b1;
               coin_type_d  = cur_type;
            end
         end

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         ST_FAULT: begin
            if (clear_fault) begin
               fault_d = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            coin_valid_d = 1'b0;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         coin_valid_q <= 1'b0;
         coin_type_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         item_q       <= '0;
         total_q      <= '0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         coin_valid_q <= coin_valid_d;
         coin_type_q  <= coin_type_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         item_q       <= item_d;
         total_q      <= total_d;
         fault_q      <= fault_d;
      end
   end

   assign ej.coin_valid = coin_valid_q;
   assign ej.coin_type  = coin_type_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign item_out      = item_q;
   assign total_cents   = total_q;
   assign fault         = fault_q;

endmodule
